// File: rtl/rr_blocking_arbiter.sv
// rr_blocking_arbiter
//   Round-robin scheduler that shares one blocking output channel between
//   N blocking input channels. A word moves on a channel when its sync and
//   notify are both high at a rising clk edge. Each completed transfer
//   reports the served requester on grant_out with a one-cycle notify pulse.
//
// Ports
//   clk              clock, all logic on the rising edge
//   rst              synchronous active-high reset
//   req_in           requester data, channel i at [i*DW +: DW]
//   req_in_sync      requester i offers data
//   req_in_notify    arbiter ready to read channel i (registered, one-hot or 0)
//   arb_out          forwarded data word (registered, held until accepted)
//   arb_out_notify   arb_out valid (registered)
//   arb_out_sync     consumer accepts arb_out
//   grant_out        index of the last served requester
//   grant_out_notify one-cycle pulse when grant_out updates
//   transfer_count   completed transfers, wraps modulo 2^CW
module rr_blocking_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 16,
    localparam int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] req_in,
    input  logic [N-1:0]    req_in_sync,
    output logic [N-1:0]    req_in_notify,
    output logic [DW-1:0]   arb_out,
    output logic            arb_out_notify,
    input  logic            arb_out_sync,
    output logic [GW-1:0]   grant_out,
    output logic            grant_out_notify,
    output logic [CW-1:0]   transfer_count
);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [GW-1:0]   ptr_r, ptr_s;
    logic [GW-1:0]   sel_r, sel_s;
    logic [N-1:0]    req_notify_r, req_notify_s;
    logic [DW-1:0]   arb_data_r, arb_data_s;
    logic            arb_valid_r, arb_valid_s;
    logic [GW-1:0]   grant_r, grant_s;
    logic            grant_notify_r, grant_notify_s;
    logic [CW-1:0]   count_r, count_s;

    logic            found_s;
    logic [GW-1:0]   win_s;
    logic [GW:0]     idx_s;

    // Rotating priority search: first requester at or after ptr, wrapping at N
    // explicitly so non-power-of-two N never selects a nonexistent channel.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr_r} + (GW+1)'(k);
            if (idx_s >= (GW+1)'(N)) begin
                idx_s = idx_s - (GW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_in_sync[idx_s[GW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[GW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic of the SCAN -> READ -> WRITE handshake sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SCAN: begin
                if (found_s) begin
                    state_s = READ;
                end else begin
                    state_s = SCAN;
                end
            end
            READ: begin
                // A requester that withdrew is skipped without moving ptr.
                if (req_in_sync[sel_r]) begin
                    state_s = WRITE;
                end else begin
                    state_s = SCAN;
                end
            end
            WRITE: begin
                if (arb_out_sync) begin
                    state_s = SCAN;
                end else begin
                    state_s = WRITE;
                end
            end
            default: state_s = SCAN;
        endcase
    end

    // Next values of the registered outputs and datapath state.
    always_comb begin
        ptr_s          = ptr_r;
        sel_s          = sel_r;
        req_notify_s   = '0;
        arb_data_s     = arb_data_r;
        arb_valid_s    = arb_valid_r;
        grant_s        = grant_r;
        grant_notify_s = 1'b0;
        count_s        = count_r;
        case (state_r)
            SCAN: begin
                if (found_s) begin
                    sel_s        = win_s;
                    req_notify_s = {{(N-1){1'b0}}, 1'b1} << win_s;
                end else begin
                    req_notify_s = '0;
                end
            end
            READ: begin
                if (req_in_sync[sel_r]) begin
                    arb_data_s  = req_in[sel_r*DW +: DW];
                    arb_valid_s = 1'b1;
                end else begin
                    arb_valid_s = 1'b0;
                end
            end
            WRITE: begin
                if (arb_out_sync) begin
                    arb_valid_s    = 1'b0;
                    grant_s        = sel_r;
                    grant_notify_s = 1'b1;
                    count_s        = count_r + CW'(1);
                    if (sel_r == GW'(N-1)) begin
                        ptr_s = '0;
                    end else begin
                        ptr_s = sel_r + GW'(1);
                    end
                end else begin
                    arb_valid_s = 1'b1;
                end
            end
            default: begin
                arb_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= SCAN;
            ptr_r          <= '0;
            sel_r          <= '0;
            req_notify_r   <= '0;
            arb_data_r     <= '0;
            arb_valid_r    <= 1'b0;
            grant_r        <= '0;
            grant_notify_r <= 1'b0;
            count_r        <= '0;
        end else begin
            state_r        <= state_s;
            ptr_r          <= ptr_s;
            sel_r          <= sel_s;
            req_notify_r   <= req_notify_s;
            arb_data_r     <= arb_data_s;
            arb_valid_r    <= arb_valid_s;
            grant_r        <= grant_s;
            grant_notify_r <= grant_notify_s;
            count_r        <= count_s;
        end
    end

    assign req_in_notify    = req_notify_r;
    assign arb_out          = arb_data_r;
    assign arb_out_notify   = arb_valid_r;
    assign grant_out        = grant_r;
    assign grant_out_notify = grant_notify_r;
    assign transfer_count   = count_r;

endmodule

// File: tb/tb_rr_blocking_arbiter.sv
module tb_rr_blocking_arbiter;

    logic          clk;
    logic          rst;
    logic [127:0]  req_in;
    logic [3:0]    req_in_sync;
    logic [3:0]    req_in_notify;
    logic [31:0]   arb_out;
    logic          arb_out_notify;
    logic          arb_out_sync;
    logic [1:0]    grant_out;
    logic          grant_out_notify;
    logic [15:0]   transfer_count;

    logic [3:0]    w_rn;
    logic [31:0]   w_ao;
    logic          w_an;
    logic [1:0]    w_g;
    logic          w_gn;
    logic [3:0]    w_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    rr_blocking_arbiter #(.N(4), .DW(32), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .req_in(req_in), .req_in_sync(req_in_sync),
        .req_in_notify(req_in_notify), .arb_out(arb_out), .arb_out_notify(arb_out_notify),
        .arb_out_sync(arb_out_sync), .grant_out(grant_out), .grant_out_notify(grant_out_notify),
        .transfer_count(transfer_count)
    );

    // Narrow-counter instance sharing the same stimulus, used for the wrap check.
    rr_blocking_arbiter #(.N(4), .DW(32), .CW(4)) u_dut_wrap (
        .clk(clk), .rst(rst), .req_in(req_in), .req_in_sync(req_in_sync),
        .req_in_notify(w_rn), .arb_out(w_ao), .arb_out_notify(w_an),
        .arb_out_sync(arb_out_sync), .grant_out(w_g), .grant_out_notify(w_gn),
        .transfer_count(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sync;
        logic        aos;
        logic [3:0]  e_rn;
        logic        e_an;
        logic [31:0] e_ao;
        logic        e_gn;
        logic [1:0]  e_g;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard pop and invariants for the current cycle, then advance one edge.
    task automatic cyc();
        logic [31:0] e;
        if (arb_out_notify && arb_out_sync) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected word %0h, expected none", arb_out);
            end else begin
                e = exp_q.pop_front();
                chk("scoreboard", arb_out, e);
            end
        end
        chk("onehot_req_notify", {31'd0, ($countones(req_in_notify) <= 1)}, 32'd1);
        chk("notify_exclusive", {31'd0, (arb_out_notify && (|req_in_notify))}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rn"}, req_in_notify, 32'h0);
        chk({tag, "_an"}, arb_out_notify, 32'h0);
        chk({tag, "_ao"}, arb_out, 32'h0);
        chk({tag, "_gn"}, grant_out_notify, 32'h0);
        chk({tag, "_g"}, grant_out, 32'h0);
        chk({tag, "_cnt"}, transfer_count, 32'h0);
        chk({tag, "_wcnt"}, w_cnt, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_in_sync = 4'b0000;
        arb_out_sync = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        bit seen;
        req_in = '0;
        do_reset();
        check_reset_state("reset");

        // Single requester, ptr advance to 3, then backpressure on channel 0.
        req_in = {32'h33, 32'h1337, 32'h11, 32'hAA};
        vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 32'h0,    1'b0, 2'd0, 16'd0};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 32'h1337, 1'b0, 2'd0, 16'd0};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h1337, 1'b1, 2'd2, 16'd1};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h1337, 1'b0, 2'd2, 16'd1};
        vecs[4]  = '{4'b1001, 1'b0, 4'b1000, 1'b0, 32'h1337, 1'b0, 2'd2, 16'd1};
        vecs[5]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 32'h33,   1'b0, 2'd2, 16'd1};
        vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 32'h33,   1'b0, 2'd2, 16'd1};
        vecs[7]  = '{4'b1001, 1'b1, 4'b0000, 1'b0, 32'h33,   1'b1, 2'd3, 16'd2};
        vecs[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 32'h33,   1'b0, 2'd3, 16'd2};
        vecs[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 32'hAA,   1'b0, 2'd3, 16'd2};
        for (int i = 10; i < 15; i++) begin
            vecs[i] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 32'hAA, 1'b0, 2'd3, 16'd2};
        end
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'hAA,   1'b1, 2'd0, 16'd3};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'hAA,   1'b0, 2'd0, 16'd3};
        exp_q.push_back(32'h1337);
        exp_q.push_back(32'h33);
        exp_q.push_back(32'hAA);
        for (int i = 0; i < 17; i++) begin
            req_in_sync  = vecs[i].sync;
            arb_out_sync = vecs[i].aos;
            cyc();
            chk($sformatf("vec%0d_rn", i),  req_in_notify,    vecs[i].e_rn);
            chk($sformatf("vec%0d_an", i),  arb_out_notify,   vecs[i].e_an);
            chk($sformatf("vec%0d_ao", i),  arb_out,          vecs[i].e_ao);
            chk($sformatf("vec%0d_gn", i),  grant_out_notify, vecs[i].e_gn);
            chk($sformatf("vec%0d_g", i),   grant_out,        vecs[i].e_g);
            chk($sformatf("vec%0d_cnt", i), transfer_count,   vecs[i].e_cnt);
        end

        // Reset while a word is waiting in WRITE.
        req_in_sync  = 4'b0010;
        arb_out_sync = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cyc();
            seen = arb_out_notify;
        end
        chk("rst_mid_write_reach", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        cyc();
        check_reset_state("rst_mid_write");
        rst = 1'b0;
        req_in_sync = 4'b0000;
        cyc();
        chk("post_rst_idle_rn", req_in_notify, 32'h0);
        chk("post_rst_idle_an", arb_out_notify, 32'h0);

        // Withdrawal in READ, then channel 3 is served.
        req_in_sync = 4'b0010;
        cyc();
        chk("wd_rn", req_in_notify, 32'h2);
        req_in_sync = 4'b0000;
        cyc();
        chk("wd_rn_clear", req_in_notify, 32'h0);
        chk("wd_an", arb_out_notify, 32'h0);
        chk("wd_cnt", transfer_count, 32'h0);
        req_in_sync  = 4'b1000;
        arb_out_sync = 1'b1;
        exp_q.push_back(32'h33);
        cyc();
        chk("wd3_rn", req_in_notify, 32'h8);
        cyc();
        chk("wd3_an", arb_out_notify, 32'h1);
        chk("wd3_ao", arb_out, 32'h33);
        req_in_sync = 4'b0000;
        cyc();
        chk("wd3_gn", grant_out_notify, 32'h1);
        chk("wd3_g", grant_out, 32'h3);
        chk("wd3_cnt", transfer_count, 32'h1);
        cyc();
        chk("wd3_gn_pulse", grant_out_notify, 32'h0);

        // Round-robin with all channels always requesting; 16 transfers wrap CW=4.
        do_reset();
        check_reset_state("rr_reset");
        req_in = {32'd13, 32'd12, 32'd11, 32'd10};
        for (int t = 0; t < 16; t++) begin
            exp_q.push_back(32'd10 + 32'(t % 4));
        end
        req_in_sync  = 4'b1111;
        arb_out_sync = 1'b1;
        k = 0;
        for (int c = 1; c <= 48; c++) begin
            cyc();
            if (grant_out_notify) begin
                chk($sformatf("rr_grant%0d", k), grant_out, 32'(k % 4));
                chk($sformatf("rr_cycle%0d", k), c, 32'(3 * (k + 1)));
                k++;
            end
        end
        req_in_sync = 4'b0000;
        cyc();
        chk("rr_grants", k, 32'd16);
        chk("rr_cnt", transfer_count, 32'd16);
        chk("wrap_cnt", w_cnt, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
